// File: rtl/red_add_acc_ctrl.sv
// Accumulates NUM_ACC beats from the reduction adder (fewer if last_i arrives early), adds the
// bias latched at the group's first beat, and emits one narrowed result per group on a
// valid/last/ready stream.
// Optional build macro RED_ADD_ACC_SAT_EN: when defined the result saturates to the BW_O range;
// when undefined it keeps the low BW_O bits (two's-complement wrap).
module red_add_acc_ctrl #(
  parameter int unsigned BW_I    = 32,
  parameter int unsigned BW_O    = 32,
  parameter int unsigned NUM_ACC = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [BW_I-1:0] cfg_bias_i,
  input  logic            cfg_wr_i,
  input  logic [BW_I-1:0] data_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            ready_o,
  output logic [BW_O-1:0] data_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_i
);

  // Wide enough for bias plus NUM_ACC beats without overflow.
  localparam int unsigned BW_ACC = BW_I + $clog2(NUM_ACC) + 1;
  localparam int unsigned CntW   = $clog2(NUM_ACC + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                   state_q;
  logic signed [BW_I-1:0]   bias_q;
  logic signed [BW_ACC-1:0] acc_q;
  logic [CntW-1:0]          cnt_q;
  logic [BW_O-1:0]          data_q;
  logic                     valid_q;
  logic                     last_q;

  logic signed [BW_ACC-1:0] acc_base;
  logic signed [BW_ACC-1:0] acc_sum;
  logic [CntW-1:0]          cnt_inc;
  logic                     close;
  logic [BW_O-1:0]          result;

`ifdef RED_ADD_ACC_SAT_EN
  localparam int unsigned WideW = (BW_ACC > BW_O) ? BW_ACC : BW_O;
  localparam logic signed [WideW-1:0] SatMax = {{(WideW-BW_O+1){1'b0}}, {(BW_O-1){1'b1}}};
  localparam logic signed [WideW-1:0] SatMin = {{(WideW-BW_O+1){1'b1}}, {(BW_O-1){1'b0}}};
  logic signed [WideW-1:0] sum_wide;
`endif

  // Running sum for this beat: a group's first beat starts from the bias, later ones from acc.
  always_comb begin
    acc_base = (state_q == StIdle) ? BW_ACC'(bias_q) : acc_q;
    acc_sum  = acc_base + BW_ACC'($signed(data_i));
    // cnt_q is zero in StIdle, so NUM_ACC==1 closes on the first beat.
    cnt_inc  = cnt_q + CntW'(1);
    close    = (cnt_inc == CntW'(NUM_ACC)) || last_i;
  end

  // Narrow the accumulator to the output width.
  always_comb begin
`ifdef RED_ADD_ACC_SAT_EN
    sum_wide = WideW'(acc_sum);
    if (sum_wide > SatMax) begin
      result = BW_O'(SatMax);
    end else if (sum_wide < SatMin) begin
      result = BW_O'(SatMin);
    end else begin
      result = BW_O'(sum_wide);
    end
`else
    result = BW_O'(acc_sum);
`endif
  end

  // Sequencer FSM with registered result outputs; bias register writable in any state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      bias_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (cfg_wr_i) begin
        bias_q <= $signed(cfg_bias_i);
      end
      unique case (state_q)
        StIdle, StAcc: begin
          if (valid_i) begin
            acc_q <= acc_sum;
            if (close) begin
              cnt_q   <= '0;
              data_q  <= result;
              last_q  <= last_i;
              valid_q <= 1'b1;
              state_q <= StOut;
            end else begin
              cnt_q   <= cnt_inc;
              state_q <= StAcc;
            end
          end
        end
        StOut: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = rst_n_i && (state_q != StOut);
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule
